// File: rtl/hd44780_sequencer.sv
// Command/data scheduler in front of hd44780_controller: FIFO-buffers host writes,
// issues them over the STB/busy handshake and tracks the cursor with auto line wrap.
module hd44780_sequencer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int COLS        = 16,
  parameter int ACK_TIMEOUT = 15,
  parameter bit AUTO_WRAP   = 1'b1
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                STB_I,
  input  logic                i_rs,
  input  logic [7:0]          i_data,
  output logic                o_full,
  output logic                o_empty,
  output logic [DEPTH_LOG2:0] o_count,
  output logic                o_overflow,
  output logic                o_err,
  output logic                o_cont_stb,
  output logic                o_cont_rs,
  output logic [7:0]          o_cont_data,
  input  logic                i_cont_busy,
  output logic [3:0]          o_col,
  output logic                o_row
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [3:0]    COL_MAX = 4'(COLS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_WRAP      = 3'd4;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } entry_t;

  entry_t                r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [2:0]            r_state;
  logic [TW-1:0]         r_to_cnt;
  logic                  r_ovf, r_err, r_is_wrap;
  logic                  r_cont_rs;
  logic [7:0]            r_cont_data;
  logic [3:0]            r_col;
  logic                  r_row;

  logic       w_push, w_pop, w_to_hit, w_done, w_wrap_req;
  logic [2:0] w_state_nxt;
  logic [3:0] w_col_nxt, w_data_col;
  logic       w_row_nxt;
  entry_t     w_head;

  // Count MSB is set only at exactly DEPTH entries.
  assign o_full      = r_count[DEPTH_LOG2];
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_overflow  = r_ovf;
  assign o_err       = r_err;
  assign o_cont_stb  = (r_state == S_ISSUE) || (r_state == S_WRAP);
  assign o_cont_rs   = r_cont_rs;
  assign o_cont_data = r_cont_data;
  assign o_col       = r_col;
  assign o_row       = r_row;

  assign w_push   = STB_I && !o_full;
  assign w_pop    = (r_state == S_ISSUE);
  assign w_head   = r_mem[r_rptr];
  assign w_to_hit = (r_state == S_WAIT_ACK) && !i_cont_busy && (r_to_cnt == TO_LAST);
  assign w_done   = (r_state == S_WAIT_DONE) && !i_cont_busy;

  always_ff @(posedge CLK_I) begin
    if (w_push) r_mem[r_wptr] <= entry_t'({i_rs, i_data});
  end

  assign w_data_col = (r_cont_data[3:0] > COL_MAX) ? COL_MAX : r_cont_data[3:0];

  // Cursor effect of the entry just completed; a wrap command never moves it again.
  always_comb begin
    w_col_nxt  = r_col;
    w_row_nxt  = r_row;
    w_wrap_req = 1'b0;
    if (r_cont_rs) begin
      if (r_col == COL_MAX) begin
        w_col_nxt  = 4'd0;
        w_row_nxt  = ~r_row;
        w_wrap_req = AUTO_WRAP && !r_is_wrap;
      end else begin
        w_col_nxt = r_col + 4'd1;
      end
    end else if (r_cont_data == 8'h01 || r_cont_data == 8'h02) begin
      w_col_nxt = 4'd0;
      w_row_nxt = 1'b0;
    end else if (r_cont_data[7]) begin
      w_col_nxt = w_data_col;
      w_row_nxt = r_cont_data[6];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (!o_empty && !i_cont_busy) w_state_nxt = S_ISSUE;
      S_ISSUE:     w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:  if (i_cont_busy) w_state_nxt = S_WAIT_DONE;
                   else if (w_to_hit) w_state_nxt = S_IDLE;
      S_WAIT_DONE: if (!i_cont_busy) w_state_nxt = w_wrap_req ? S_WRAP : S_IDLE;
      S_WRAP:      w_state_nxt = S_WAIT_ACK;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_to_cnt    <= '0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_is_wrap   <= 1'b0;
      r_cont_rs   <= 1'b0;
      r_cont_data <= 8'h00;
      r_col       <= 4'd0;
      r_row       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      if (w_push && !w_pop)      r_count <= r_count + (DEPTH_LOG2+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (DEPTH_LOG2+1)'(1);
      if (STB_I && o_full) r_ovf <= 1'b1;
      if (w_to_hit)        r_err <= 1'b1;

      if (w_state_nxt == S_WAIT_ACK && r_state != S_WAIT_ACK) r_to_cnt <= '0;
      else if (r_state == S_WAIT_ACK && !i_cont_busy)         r_to_cnt <= r_to_cnt + TW'(1);

      if (r_state == S_IDLE && w_state_nxt == S_ISSUE) begin
        r_cont_rs   <= w_head.rs;
        r_cont_data <= w_head.data;
        r_is_wrap   <= 1'b0;
      end

      if (w_done) begin
        if (!r_is_wrap) begin
          r_col <= w_col_nxt;
          r_row <= w_row_nxt;
        end
        if (w_wrap_req) begin
          r_cont_rs   <= 1'b0;
          r_cont_data <= {1'b1, w_row_nxt, 6'b0};
          r_is_wrap   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hd44780_sequencer.sv
// Scoreboard bench for hd44780_sequencer: a cursor model predicts every controller
// strobe (including inserted wraps) at push time; strobes pop and compare.
module tb_hd44780_sequencer;
  localparam int COLS = 16;

  logic       CLK_I = 1'b0;
  logic       RST_I, STB_I, i_rs, i_cont_busy;
  logic [7:0] i_data;
  logic       o_full, o_empty, o_overflow, o_err, o_cont_stb, o_cont_rs, o_row;
  logic [4:0] o_count;
  logic [7:0] o_cont_data;
  logic [3:0] o_col;

  int total = 0;
  int bad   = 0;

  logic [8:0] sb_q[$];
  logic [3:0] mcol = 4'd0;
  logic       mrow = 1'b0;
  int         busy_cnt = 0;
  bit         hold = 1'b0;
  bit         no_ack = 1'b0;

  hd44780_sequencer #(.DEPTH_LOG2(4), .COLS(COLS), .ACK_TIMEOUT(15), .AUTO_WRAP(1'b1)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .i_rs(i_rs), .i_data(i_data),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_overflow(o_overflow),
    .o_err(o_err), .o_cont_stb(o_cont_stb), .o_cont_rs(o_cont_rs),
    .o_cont_data(o_cont_data), .i_cont_busy(i_cont_busy), .o_col(o_col), .o_row(o_row)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Controller model: busy rises right after a strobe and stays high 3..20 cycles.
  always @(negedge CLK_I) begin
    if (busy_cnt > 0) busy_cnt--;
    if (o_cont_stb && !no_ack) busy_cnt = $urandom_range(3, 20);
    i_cont_busy = hold || (busy_cnt > 0);
  end

  always @(negedge CLK_I) begin
    if (RST_I && o_cont_stb) begin
      if (sb_q.size() == 0) chk("stb_unexp", 32'(o_cont_stb), 32'd0);
      else chk("issue", 32'({o_cont_rs, o_cont_data}), 32'(sb_q.pop_front()));
    end
  end

  task automatic model_push(input logic rs, input logic [7:0] d);
    sb_q.push_back({rs, d});
    if (rs) begin
      if (mcol == 4'(COLS - 1)) begin
        mcol = 4'd0;
        mrow = ~mrow;
        sb_q.push_back({1'b0, (mrow ? 8'hC0 : 8'h80)});
      end else mcol = mcol + 4'd1;
    end else if (d == 8'h01 || d == 8'h02) begin
      mcol = 4'd0;
      mrow = 1'b0;
    end else if (d[7]) begin
      mrow = d[6];
      mcol = (d[3:0] > 4'(COLS - 1)) ? 4'(COLS - 1) : d[3:0];
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] d, input bit acc);
    STB_I = 1'b1; i_rs = rs; i_data = d;
    if (acc) model_push(rs, d);
    @(negedge CLK_I);
    STB_I = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (sb_q.size() == 0 && busy_cnt == 0 && o_empty && !o_cont_stb) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK_I);
    end
    chk("drain", 32'(ok), 32'd1);
    repeat (3) @(negedge CLK_I);
  endtask

  task automatic wait_stb(input logic [7:0] d, input bit any, output bit found);
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (o_cont_stb && (any || o_cont_data == d)) begin
        found = 1'b1;
        break;
      end
      @(negedge CLK_I);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    RST_I = 1'b0; STB_I = 1'b0; i_rs = 1'b0; i_data = 8'h00;
    repeat (3) @(negedge CLK_I);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_stb", 32'(o_cont_stb), 32'd0);
    chk("rst_flags", 32'({o_full, o_overflow, o_err}), 32'd0);
    chk("rst_cursor", 32'({o_row, o_col}), 32'd0);
    RST_I = 1'b1;
    @(negedge CLK_I);

    // Single data byte: strobe two cycles after the push.
    push(1'b1, 8'h6D, 1'b1);
    chk("lat1_stb", 32'(o_cont_stb), 32'd0);
    @(negedge CLK_I);
    chk("lat2_stb", 32'(o_cont_stb), 32'd1);
    chk("lat2_ent", 32'({o_cont_rs, o_cont_data}), 32'h16D);
    drain();
    chk("t1_col", 32'(o_col), 32'd1);
    chk("t1_empty", 32'(o_empty), 32'd1);
    chk("t1_ovf", 32'(o_overflow), 32'd0);

    // Fill past capacity while the controller is busy.
    hold = 1'b1;
    @(negedge CLK_I);
    for (int i = 0; i < 17; i++) push(1'b1, 8'(8'h60 + i), i < 16);
    chk("fill_count", 32'(o_count), 32'd16);
    chk("fill_full", 32'(o_full), 32'd1);
    chk("fill_ovf", 32'(o_overflow), 32'd1);
    hold = 1'b0;
    drain();
    chk("t2_cursor", 32'({o_row, o_col}), 32'({mrow, mcol}));

    // Full line of 16 chars -> wrap C0, then an entry pushed during the wrap.
    push(1'b0, 8'h01, 1'b1);
    drain();
    for (int i = 0; i < 16; i++) push(1'b1, 8'(8'h41 + i), 1'b1);
    wait_stb(8'hC0, 1'b0, found);
    chk("wrap_seen", 32'(found), 32'd1);
    push(1'b1, 8'h51, 1'b1);
    drain();
    chk("wrap_row", 32'(o_row), 32'd1);
    chk("wrap_col", 32'(o_col), 32'd1);

    // Set-DDRAM then clear: no wrap, cursor follows commands.
    push(1'b0, 8'h8A, 1'b1);
    drain();
    chk("ddram_cursor", 32'({o_row, o_col}), 32'h0A);
    push(1'b0, 8'h01, 1'b1);
    drain();
    chk("clear_cursor", 32'({o_row, o_col}), 32'h00);

    // Controller never acks the first entry.
    no_ack = 1'b1;
    push(1'b0, 8'h0C, 1'b1);
    push(1'b1, 8'h5A, 1'b1);
    wait_stb(8'h0C, 1'b0, found);
    chk("to_stb_seen", 32'(found), 32'd1);
    repeat (15) @(negedge CLK_I);
    chk("to_err_early", 32'(o_err), 32'd0);
    @(negedge CLK_I);
    chk("to_err_set", 32'(o_err), 32'd1);
    no_ack = 1'b0;
    drain();
    chk("to_cursor", 32'({o_row, o_col}), 32'h01);

    // Async reset while waiting for the controller to finish.
    push(1'b1, 8'h33, 1'b1);
    wait_stb(8'h33, 1'b0, found);
    chk("rst_stb_seen", 32'(found), 32'd1);
    push(1'b1, 8'h34, 1'b1);
    @(negedge CLK_I);
    RST_I = 1'b0;
    #1;
    chk("arst_stb", 32'(o_cont_stb), 32'd0);
    chk("arst_count", 32'(o_count), 32'd0);
    chk("arst_cursor", 32'({o_row, o_col}), 32'd0);
    chk("arst_flags", 32'({o_overflow, o_err}), 32'd0);
    chk("arst_data", 32'({o_cont_rs, o_cont_data}), 32'd0);
    sb_q.delete();
    mcol = 4'd0;
    mrow = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);
    chk("post_rst_empty", 32'(o_empty), 32'd1);
    push(1'b1, 8'h21, 1'b1);
    drain();
    chk("post_rst_cursor", 32'({o_row, o_col}), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
